// File: rtl/mdu_sequencer.sv
// Iterative RV32M multiply/divide sequencer: 32-step shift-add multiply
// or restoring divide on magnitudes, followed by a sign-fix cycle.
module mdu_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      Funct3,
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    output logic [XLEN-1:0] Result,
    output logic            busy,
    output logic            done
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t              state_q;
    logic [CW-1:0]       cnt_q;
    logic [2:0]          op_q;
    logic [XLEN-1:0]     a_q, ma_q, mb_q;
    logic                sa_q, neg_q, dz_q, ov_q;
    logic [2*XLEN-1:0]   prod_q;
    logic [XLEN:0]       rem_q;
    logic [XLEN-1:0]     quo_q;
    logic [XLEN-1:0]     res_q;
    logic                busy_q, done_q;

    logic                accept;
    logic                a_sgn, b_sgn;
    logic                sa_d, sb_d, dz_d, ov_d;
    logic [XLEN-1:0]     ma_d, mb_d;
    logic [XLEN:0]       msum;
    logic [XLEN+1:0]     dshift, ddiff;
    logic [2*XLEN-1:0]   pfix;
    logic [XLEN-1:0]     qfix, rfix, res_d;

    assign accept = start && (state_q == IDLE || state_q == DONE);

    always_comb begin
        a_sgn = (Funct3 == 3'b001) || (Funct3 == 3'b010) ||
                (Funct3 == 3'b100) || (Funct3 == 3'b110);
        b_sgn = (Funct3 == 3'b001) || (Funct3 == 3'b100) ||
                (Funct3 == 3'b110);
        sa_d  = a_sgn & SrcA[XLEN-1];
        sb_d  = b_sgn & SrcB[XLEN-1];
        ma_d  = sa_d ? ('0 - SrcA) : SrcA;
        mb_d  = sb_d ? ('0 - SrcB) : SrcB;
        dz_d  = (SrcB == '0);
        // Only DIV/REM (Funct3[2]=1, Funct3[0]=0) can overflow
        ov_d  = Funct3[2] & ~Funct3[0] &
                (SrcA == {1'b1, {(XLEN-1){1'b0}}}) & (&SrcB);
    end

    always_comb begin
        msum   = {1'b0, prod_q[2*XLEN-1:XLEN]} +
                 (prod_q[0] ? {1'b0, ma_q} : '0);
        dshift = {rem_q, quo_q[XLEN-1]};
        ddiff  = dshift - {2'b00, mb_q};
        pfix   = neg_q ? ('0 - prod_q) : prod_q;
        qfix   = neg_q ? ('0 - quo_q) : quo_q;
        rfix   = sa_q ? ('0 - rem_q[XLEN-1:0]) : rem_q[XLEN-1:0];
        res_d  = '0;
        unique case (op_q)
            3'b000: res_d = pfix[XLEN-1:0];
            3'b001, 3'b010, 3'b011:
                res_d = pfix[2*XLEN-1:XLEN];
            3'b100, 3'b101:
                res_d = dz_q ? '1 :
                        ov_q ? {1'b1, {(XLEN-1){1'b0}}} : qfix;
            3'b110, 3'b111:
                res_d = dz_q ? a_q : ov_q ? '0 : rfix;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            ma_q    <= '0;
            mb_q    <= '0;
            sa_q    <= 1'b0;
            neg_q   <= 1'b0;
            dz_q    <= 1'b0;
            ov_q    <= 1'b0;
            prod_q  <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            res_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                state_q <= CALC;
                busy_q  <= 1'b1;
                cnt_q   <= '0;
                op_q    <= Funct3;
                a_q     <= SrcA;
                ma_q    <= ma_d;
                mb_q    <= mb_d;
                sa_q    <= sa_d;
                neg_q   <= sa_d ^ sb_d;
                dz_q    <= dz_d;
                ov_q    <= ov_d;
                prod_q  <= {{XLEN{1'b0}}, mb_d};
                rem_q   <= '0;
                quo_q   <= ma_d;
            end else begin
                unique case (state_q)
                    IDLE: ;
                    CALC: begin
                        cnt_q  <= cnt_q + 1'b1;
                        prod_q <= {msum, prod_q[XLEN-1:1]};
                        // Restore when the trial subtraction borrows
                        if (ddiff[XLEN+1]) begin
                            rem_q <= dshift[XLEN:0];
                            quo_q <= {quo_q[XLEN-2:0], 1'b0};
                        end else begin
                            rem_q <= ddiff[XLEN:0];
                            quo_q <= {quo_q[XLEN-2:0], 1'b1};
                        end
                        if (cnt_q == CW'(XLEN - 1))
                            state_q <= FIX;
                    end
                    FIX: begin
                        res_q   <= res_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                    DONE: state_q <= IDLE;
                endcase
            end
        end
    end

    assign Result = res_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer with a result scoreboard queue
// and latency/handshake checks.
module tb_mdu_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  Funct3;
    logic [31:0] SrcA, SrcB;
    logic [31:0] Result;
    logic        busy, done;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    mdu_sequencer #(.XLEN(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .Funct3 (Funct3),
        .SrcA   (SrcA),
        .SrcB   (SrcB),
        .Result (Result),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; leaves the bench at the negedge after accept.
    task automatic issue(input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] e,
                         input bit push);
        start  = 1'b1;
        Funct3 = f;
        SrcA   = a;
        SrcB   = b;
        if (push) exp_q.push_back(e);
        @(negedge clk);
        start  = 1'b0;
        Funct3 = 3'($urandom);
        SrcA   = $urandom;
        SrcB   = $urandom;
    endtask

    // Cycle 1 is the one following the accepting edge.
    task automatic wait_done(input string tag);
        int n;
        logic [31:0] e;
        n = 1;
        chk({tag, " busy"}, {31'b0, busy}, 32'd1);
        while (done !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " latency"}, n, 32'd34);
        chk({tag, " busy@done"}, {31'b0, busy}, 32'd0);
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = 32'hDEADBEEF;
        chk({tag, " result"}, Result, e);
    endtask

    task automatic run(input string tag, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] e);
        issue(f, a, b, e, 1'b1);
        wait_done(tag);
        @(negedge clk);
        chk({tag, " pulse"}, {31'b0, done}, 32'd0);
        chk({tag, " hold"}, Result, e);
    endtask

    initial begin
        logic [31:0] held;
        int seen;
        reset  = 1'b1;
        start  = 1'b0;
        Funct3 = '0;
        SrcA   = '0;
        SrcB   = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst Result", Result, 32'h0);
        chk("rst busy", {31'b0, busy}, 32'd0);
        chk("rst done", {31'b0, done}, 32'd0);

        run("MUL", 3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB);
        run("MULH", 3'b001, 32'h80000000, 32'h80000000, 32'h40000000);
        run("MULHU", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
        run("MULHSU", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run("DIV", 3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD);
        run("REM", 3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF);
        run("DIVU", 3'b101, 32'd100, 32'd7, 32'd14);
        run("REMU", 3'b111, 32'd100, 32'd7, 32'd2);
        run("DIVU0", 3'b101, 32'd5, 32'd0, 32'hFFFFFFFF);
        run("REMU0", 3'b111, 32'd5, 32'd0, 32'd5);
        run("REM0", 3'b110, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9);
        run("DIVOV", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
        run("REMOV", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h0);

        // A start while busy must be dropped, not queued
        issue(3'b000, 32'd6, 32'd9, 32'd54, 1'b1);
        repeat (4) @(negedge clk);
        start  = 1'b1;
        Funct3 = 3'b101;
        SrcA   = 32'd1000;
        SrcB   = 32'd10;
        @(negedge clk);
        start = 1'b0;
        seen = 0;
        while (done !== 1'b1 && seen < 60) begin
            @(negedge clk);
            seen++;
        end
        chk("ignore done", {31'b0, done}, 32'd1);
        chk("ignore result", Result, exp_q.size() > 0 ?
            exp_q.pop_front() : 32'hDEADBEEF);
        repeat (3) @(negedge clk);
        chk("ignore idle", {31'b0, busy}, 32'd0);

        // Back-to-back: second start lands in the DONE cycle
        issue(3'b101, 32'd81, 32'd9, 32'd9, 1'b1);
        wait_done("B2B1");
        issue(3'b000, 32'd11, 32'd13, 32'd143, 1'b1);
        wait_done("B2B2");
        @(negedge clk);

        // Reset at iteration 10 discards the divide
        issue(3'b100, 32'd1000, 32'd7, 32'd0, 1'b0);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst busy", {31'b0, busy}, 32'd0);
        chk("midrst done", {31'b0, done}, 32'd0);
        chk("midrst Result", Result, 32'h0);
        held = 32'd0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) held = 32'd1;
        end
        chk("midrst nodone", held, 32'd0);
        run("MUL3x4", 3'b000, 32'd3, 32'd4, 32'd12);

        chk("sb empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
